// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message sequencer: packs a 32-bit big-endian word stream into 512-bit blocks,
// appends the 0x80 pad byte and the 64-bit bit-length field, and drives the hash core
// one block at a time.
module sha256_msg_ctrl #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    output logic         busy,
    output logic [255:0] digest,
    output logic         done
);

    typedef enum logic [2:0] {StIdle, StFill, StPad, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0][31:0]  blk_q, blk_d;        // word 0 lives at index 15 (bits [511:480])
    logic [4:0]         idx_q, idx_d;        // next free word slot, 16 = block full
    logic [LEN_W-1:0]   len_q, len_d;
    logic               first_q, first_d;    // next block starts from the IV
    logic               pend_q, pend_d;      // 0x80 pad byte still to be placed
    logic               extra_q, extra_d;    // a length-only block is still owed
    logic               end_q, end_d;        // last message word already taken
    logic               wfirst_q, wfirst_d;  // first WAIT cycle, core has not seen the pulse yet
    logic               in_ready_q, in_ready_d;
    logic               init_q, init_d;
    logic               next_q, next_d;
    logic               busy_q, busy_d;
    logic [255:0]       digest_q, digest_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [31:0]        word_w;
    logic [LEN_W-1:0]   add_len;
    logic [63:0]        len_field;
    logic [4:0]         pad_pos;

    assign xfer       = in_valid && in_ready_q;
    assign in_ready   = in_ready_q;
    assign core_init  = init_q;
    assign core_next  = next_q;
    assign core_block = blk_q;
    assign busy       = busy_q;
    assign digest     = digest_q;
    assign done       = done_q;

    // Next-state, block assembly and padding for the sequencer FSM
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        len_d      = len_q;
        first_d    = first_q;
        pend_d     = pend_q;
        extra_d    = extra_q;
        end_d      = end_q;
        wfirst_d   = wfirst_q;
        busy_d     = busy_q;
        digest_d   = digest_q;
        init_d     = 1'b0;
        next_d     = 1'b0;
        done_d     = 1'b0;
        len_field  = 64'(len_q);
        // Word holding the pad byte: the pending slot, or the partial last word
        pad_pos    = pend_q ? idx_q : idx_q - 5'd1;

        // Partial last word: keep the valid bytes and put 0x80 right after them
        word_w = in_data;
        if (in_last) begin
            case (in_bytes)
                2'd1:    word_w = {in_data[31:24], 8'h80, 16'h0000};
                2'd2:    word_w = {in_data[31:16], 8'h80, 8'h00};
                2'd3:    word_w = {in_data[31:8], 8'h80};
                default: word_w = in_data;
            endcase
        end
        add_len = (in_last && in_bytes != 2'd0) ? LEN_W'({in_bytes, 3'b000}) : LEN_W'(32'd32);

        unique case (state_q)
            StIdle, StFill: begin
                if (xfer) begin
                    busy_d = 1'b1;
                    blk_d[4'd15 - idx_q[3:0]] = word_w;
                    idx_d = idx_q + 5'd1;
                    len_d = len_q + add_len;
                    if (in_last) begin
                        end_d   = 1'b1;
                        pend_d  = (in_bytes == 2'd0);
                        state_d = StPad;
                    end else if (idx_q == 5'd15) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StPad: begin
                if (extra_q) begin
                    blk_d = '0;
                    if (pend_q) blk_d[15] = 32'h8000_0000;
                    blk_d[1] = len_field[63:32];
                    blk_d[0] = len_field[31:0];
                    extra_d  = 1'b0;
                    pend_d   = 1'b0;
                end else begin
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) >= idx_q) begin
                            blk_d[4'(15 - i)] = (pend_q && 5'(i) == idx_q) ? 32'h8000_0000 : 32'h0;
                        end
                    end
                    if (pad_pos <= 5'd13) begin
                        blk_d[1] = len_field[63:32];
                        blk_d[0] = len_field[31:0];
                    end else begin
                        extra_d = 1'b1;
                    end
                    // Only a completely full block leaves the pad byte for the next one
                    pend_d = pend_q && (idx_q == 5'd16);
                end
                state_d = StIssue;
            end
            StIssue: begin
                if (core_ready) begin
                    init_d   = first_q;
                    next_d   = !first_q;
                    first_d  = 1'b0;
                    wfirst_d = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (wfirst_q) begin
                    wfirst_d = 1'b0;
                end else if (core_ready) begin
                    if (!end_q) begin
                        idx_d   = 5'd0;
                        state_d = StFill;
                    end else if (extra_q) begin
                        idx_d   = 5'd0;
                        state_d = StPad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                digest_d = core_digest;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                len_d    = '0;
                idx_d    = 5'd0;
                first_d  = 1'b1;
                end_d    = 1'b0;
                pend_d   = 1'b0;
                extra_d  = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StFill);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            idx_q      <= 5'd0;
            len_q      <= '0;
            first_q    <= 1'b1;
            pend_q     <= 1'b0;
            extra_q    <= 1'b0;
            end_q      <= 1'b0;
            wfirst_q   <= 1'b0;
            in_ready_q <= 1'b0;
            init_q     <= 1'b0;
            next_q     <= 1'b0;
            busy_q     <= 1'b0;
            digest_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            extra_q    <= extra_d;
            end_q      <= end_d;
            wfirst_q   <= wfirst_d;
            in_ready_q <= in_ready_d;
            init_q     <= init_d;
            next_q     <= next_d;
            busy_q     <= busy_d;
            digest_q   <= digest_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: a behavioural SHA-256 core answers the pulses, a scoreboard
// holds expected blocks, pulse kinds and digests, and a negedge monitor pops and compares.
module tb_sha256_msg_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = '0;
    logic         core_init, core_next;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic         busy, done;
    logic [255:0] digest;

    logic         core_rstn = 1'b1;
    int           core_cnt;
    int           core_lat = 1;

    int errors = 0;
    int checks = 0;
    int init_cnt = 0;
    int done_cnt = 0;
    bit tail = 1'b0;

    logic [511:0] exp_blk[$];
    bit           exp_init[$];
    logic [255:0] exp_dig[$];

    always #5 clk = ~clk;

    sha256_msg_ctrl #(.LEN_W(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_block (core_block),
        .core_ready (core_ready),
        .core_digest(core_digest),
        .busy       (busy),
        .digest     (digest),
        .done       (done)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_448 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_448B = {448'h0, 64'h1c0};
    localparam logic [511:0] BLK_64B  = {32'h80000000, 416'h0, 64'h200};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-level reference padding; optional hand-computed constants override the
    // final block and the digest.
    task automatic push_expect(input byte unsigned m[$], input bit blk_known,
                               input logic [511:0] last_blk, input bit dig_known,
                               input logic [255:0] dig);
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] h;
        int           nb;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nb = p.size() / 64;
        h  = IV;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8 * j -: 8] = p[64 * bi + j];
            if (blk_known && bi == nb - 1) blk = last_blk;
            exp_blk.push_back(blk);
            exp_init.push_back(bi == 0);
            h = compress(h, blk);
        end
        exp_dig.push_back(dig_known ? dig : h);
    endtask

    // Behavioural core: latches a block on a pulse, busy for core_lat cycles
    always @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            core_ready  <= 1'b1;
            core_cnt    <= 0;
            core_digest <= '0;
        end else if (core_init || core_next) begin
            core_digest <= compress(core_init ? IV : core_digest, core_block);
            core_ready  <= 1'b0;
            core_cnt    <= core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_ready <= 1'b1;
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (core_init || core_next) begin
                if (core_init) init_cnt++;
                check("pulse_core_ready", 512'(core_ready), 512'(1));
                if (exp_blk.size() == 0) begin
                    check("unexpected_pulse", 512'(1), 512'(0));
                end else begin
                    check("block", core_block, exp_blk.pop_front());
                    check("pulse_is_init", 512'(core_init), 512'(exp_init.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                tail = 1'b0;
                if (exp_dig.size() == 0) check("unexpected_done", 512'(1), 512'(0));
                else check("digest", 512'(digest), 512'(exp_dig.pop_front()));
                check("busy_at_done", 512'(busy), 512'(0));
            end
            if (tail) check("in_ready_after_last", 512'(in_ready), 512'(0));
            if (core_ready === 1'b0) check("in_ready_core_busy", 512'(in_ready), 512'(0));
        end
    end

    // Present one word (at a negedge) until it transfers
    task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb,
                             input bit stall);
        bit acc;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        for (int t = 0; t < 3000; t++) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                if (last) tail = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        check("word_accept_timeout", 512'(1), 512'(0));
    endtask

    task automatic send_msg(input byte unsigned m[$], input bit stall, input int stop_after);
        int          nw;
        logic [31:0] d;
        nw = (m.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (stop_after >= 0 && w == stop_after) return;
            for (int j = 0; j < 4; j++) d[31 - 8 * j -: 8] = (4 * w + j < m.size()) ? m[4 * w + j] : 8'h00;
            // in_bytes varies on non-last words to show it is ignored there
            if (w == nw - 1) send_word(d, 1'b1, 2'(m.size() % 4), stall);
            else send_word(d, 1'b0, 2'(w), stall);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20000; t++) begin
            if (exp_dig.size() == 0 && exp_blk.size() == 0) return;
            @(negedge clk);
        end
        check("done_timeout", 512'(exp_dig.size()), 512'(0));
    endtask

    initial begin
        byte unsigned m_abc[$];
        byte unsigned m[$];
        string        s;
        int           i0, d0;

        m_abc = '{8'h61, 8'h62, 8'h63};
        #1 core_rstn = 1'b0;
        #1 core_rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_core_init", 512'(core_init), 512'(0));
        check("rst_core_next", 512'(core_next), 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_core_block", core_block, 512'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 512'(in_ready), 512'(1));

        // "abc": single block
        push_expect(m_abc, 1'b1, BLK_ABC, 1'b1, DIG_ABC);
        send_msg(m_abc, 1'b0, -1);
        wait_idle();

        // 56 bytes, pad byte spills into word 14 -> extra length block
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m = {};
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        push_expect(m, 1'b1, BLK_448B, 1'b1, DIG_448);
        send_msg(m, 1'b0, -1);
        wait_idle();

        // 64 bytes: pad byte starts the second block
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        push_expect(m, 1'b1, BLK_64B, 1'b0, '0);
        send_msg(m, 1'b0, -1);
        wait_idle();

        // Boundaries: pad byte in word 13 (fits) and word 14 of a partial word (spills)
        for (int n = 55; n <= 57; n += 2) begin
            m = {};
            for (int i = 0; i < n; i++) m.push_back(8'(i * 3 + n));
            push_expect(m, 1'b0, '0, 1'b0, '0);
            send_msg(m, 1'b0, -1);
            wait_idle();
        end

        // Stall: random in_valid, slow core, 541 bytes = 9 blocks, last word 1 byte
        core_lat = 7;
        m = {};
        for (int i = 0; i < 541; i++) m.push_back(8'((i * 7 + 3) & 255));
        push_expect(m, 1'b0, '0, 1'b0, '0);
        send_msg(m, 1'b1, -1);
        wait_idle();
        core_lat = 1;

        // Reset after 7 words, then "abc"
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i + 100));
        send_msg(m, 1'b0, 7);
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 512'(in_ready), 512'(0));
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_digest", 512'(digest), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        i0 = init_cnt;
        d0 = done_cnt;
        push_expect(m_abc, 1'b1, BLK_ABC, 1'b1, DIG_ABC);
        send_msg(m_abc, 1'b0, -1);
        wait_idle();
        repeat (5) @(negedge clk);
        check("midrst_init_count", 512'(init_cnt - i0), 512'(1));
        check("midrst_done_count", 512'(done_cnt - d0), 512'(1));

        // Back-to-back "abc": second must start with core_init again
        push_expect(m_abc, 1'b1, BLK_ABC, 1'b1, DIG_ABC);
        push_expect(m_abc, 1'b1, BLK_ABC, 1'b1, DIG_ABC);
        send_msg(m_abc, 1'b0, -1);
        send_msg(m_abc, 1'b0, -1);
        wait_idle();
        repeat (5) @(negedge clk);
        check("sb_blocks_left", 512'(exp_blk.size()), 512'(0));
        check("sb_digests_left", 512'(exp_dig.size()), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
